mem_sdu_dp: RTL and testbench
=============================

# mem_sdu_dp

Parametrised data memory with a CPU port and a debug (SDU) port. The CPU port has byte-lane writes and a registered read. The SDU port is a request/acknowledge channel that reads or writes one word at a time without stalling the CPU. An optional reset-time clear engine zeroes the whole array. The block replaces the fixed 1K×32 debug-readable memory in the CPU data path and sits between the pipeline's MEM stage and the serial debug unit.

## Interface
- DATA_W, 32: word width; must be a multiple of 8.
- ADDR_W, 10: word-address width; depth = 2^ADDR_W words.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_we  in  DATA_W/8  CPU byte-lane write enables; bit i writes byte i.
- cpu_re  in  1  CPU read enable.
- cpu_dout  out  DATA_W  CPU read data, registered.
- sdu_req  in  1  SDU request; held high until sdu_ack is seen.
- sdu_wr  in  1  1 = write, 0 = read; sampled with sdu_req.
- sdu_addr  in  ADDR_W  SDU word address.
- sdu_din  in  DATA_W  SDU write data (full word).
- sdu_ack  out  1  one-cycle acknowledge pulse.
- sdu_dout  out  DATA_W  SDU read data; valid with sdu_ack and held until the next read ack.
- busy  out  1  clear engine active; all accesses are blocked while high.

## Operation
- Storage: 2^ADDR_W × DATA_W array with one write port and two synchronous read ports (CPU, SDU).
- CPU read: if cpu_re and !busy, cpu_dout <= mem[cpu_addr] on the next edge. Otherwise cpu_dout holds its value.
- CPU write: if !busy, each byte lane with cpu_we[i]=1 is written on the edge.
- Read/write collision at the same address in the same cycle (either port) is read-before-write: the read returns the old data.
- Write arbitration: the CPU always wins. An SDU write is committed only in a cycle where cpu_we == 0.
- SDU FSM has three states:
  - S_IDLE: if sdu_req && !busy:
    - Read: latch sdu_dout <= mem[sdu_addr] and go to S_ACK.
    - Write with cpu_we == 0: write sdu_din to mem[sdu_addr] and go to S_ACK.
    - Write with cpu_we != 0: stay in S_IDLE (retry next cycle).
  - S_ACK: sdu_ack = 1 for exactly this cycle, then go to S_WAIT_LOW.
  - S_WAIT_LOW: when sdu_req == 0, go to S_IDLE. A still-high req is not a new request.
- sdu_addr, sdu_wr and sdu_din are sampled only in the accepting cycle. Changes after acceptance are ignored.
- Clear engine (MEM_SDU_CLEAR_EN): after reset, one word per cycle is written to 0 using an ADDR_W-bit counter running from 0 to 2^ADDR_W-1. busy drops the cycle after the last word is written.

## Timing
- Reset values: cpu_dout = 0, sdu_dout = 0, sdu_ack = 0, SDU FSM = S_IDLE, clear counter = 0. busy = 1 with MEM_SDU_CLEAR_EN, 0 without.
- CPU read latency: 1 cycle.
- SDU read: req accepted at edge N (data latched) → sdu_ack high during cycle N+1 → S_WAIT_LOW from N+2.
- SDU write: same timing. Each cycle of CPU write activity adds one cycle of delay.
- Minimum spacing between SDU transactions: 3 cycles (accept, ack, req-low seen).
- Clear duration: exactly 2^ADDR_W cycles after reset deassertion.
- Reset asserted mid-clear or mid-SDU transaction: state resets immediately. Clear restarts from address 0. A pending SDU write that was not yet committed is lost.
- An SDU request raised while busy is held off and accepted in the first cycle after busy falls.

## Configuration
- MEM_SDU_CLEAR_EN defined: clear engine present, busy behaves as above, and the array reads 0 everywhere after the clear completes.
- MEM_SDU_CLEAR_EN undefined: no counter, busy tied to 0, accesses are honoured from the first cycle after reset, and array contents after reset are undefined.

## Test plan
- With clear enabled, ADDR_W=4: release reset → busy stays high for 16 cycles. SDU reads of addresses 0..15 then return 0x00000000, each acked one cycle after acceptance.
- CPU writes 0xDEADBEEF to address 5 with cpu_we = 4'b1111, then writes 0x000000AA with cpu_we = 4'b0001 → a CPU read of address 5 returns 0xDEADBEAA one cycle after cpu_re.
- SDU write request to address 3 while cpu_we is nonzero for 4 cycles → the write is committed in cycle 5, sdu_ack pulses in cycle 6, and the CPU's writes are unaffected.
- Same-cycle CPU write 0x11111111 and SDU read of address 7 (old value 0x22222222) → sdu_dout = 0x22222222 and a later read returns 0x11111111.
- sdu_req held high for 6 cycles after ack → exactly one ack pulse. Drop req for 1 cycle and raise it again → a second transaction is accepted.
- Assert rst midway through the clear (counter = 9) → busy remains high and the clear restarts at 0, taking a full 16 cycles after reset release.

Source files
------------

// File: rtl/mem_sdu_dp.sv
// mem_sdu_dp: data memory with a byte-lane CPU port and a req/ack debug (SDU) port.
// Define MEM_SDU_CLEAR_EN to zero the whole array after every reset (busy while clearing).
module mem_sdu_dp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_din,
  input  logic [DATA_W/8-1:0]   cpu_we,
  input  logic                  cpu_re,
  output logic [DATA_W-1:0]     cpu_dout,
  input  logic                  sdu_req,
  input  logic                  sdu_wr,
  input  logic [ADDR_W-1:0]     sdu_addr,
  input  logic [DATA_W-1:0]     sdu_din,
  output logic                  sdu_ack,
  output logic [DATA_W-1:0]     sdu_dout,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT_LOW} sdu_state_t;

  sdu_state_t        state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              sdu_accept;
  logic              sdu_commit;

`ifdef MEM_SDU_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  // busy falls on the same edge that clears the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt)
        busy <= 1'b0;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // The CPU always wins the write port; an SDU write waits for a CPU-idle cycle
  assign sdu_accept = (state == S_IDLE) && sdu_req && !busy && (!sdu_wr || (cpu_we == '0));
  assign sdu_commit = sdu_accept && sdu_wr;

  always_ff @(posedge clk) begin
    if (busy) begin
`ifdef MEM_SDU_CLEAR_EN
      mem[clr_cnt] <= '0;
`endif
    end else begin
      for (int i = 0; i < NB; i++)
        if (cpu_we[i])
          mem[cpu_addr][i*8 +: 8] <= cpu_din[i*8 +: 8];
      if (sdu_commit)
        mem[sdu_addr] <= sdu_din;
    end
  end

  // Both read ports see pre-edge contents, giving read-before-write on collisions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_dout <= '0;
      sdu_dout <= '0;
    end else begin
      if (cpu_re && !busy)
        cpu_dout <= mem[cpu_addr];
      if (sdu_accept && !sdu_wr)
        sdu_dout <= mem[sdu_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sdu_ack   = 1'b0;
    case (state)
      S_IDLE:     if (sdu_accept) state_nxt = S_ACK;
      S_ACK: begin
        sdu_ack   = 1'b1;
        state_nxt = S_WAIT_LOW;
      end
      S_WAIT_LOW: if (!sdu_req) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_sdu_dp.sv
// Self-checking bench for mem_sdu_dp (ADDR_W=4): CPU vector table, SDU read scoreboard,
// hand-written sequences for arbitration, collisions, req handshake and reset behaviour.
module tb_mem_sdu_dp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef struct {
    logic [3:0]  we;
    logic [3:0]  addr;
    logic [31:0] din;
    logic        re;
    logic [31:0] exp_dout;
  } cpu_vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [3:0]        cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_dout;
  logic              sdu_req;
  logic              sdu_wr;
  logic [ADDR_W-1:0] sdu_addr;
  logic [DATA_W-1:0] sdu_din;
  logic              sdu_ack;
  logic [DATA_W-1:0] sdu_dout;
  logic              busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  cpu_vec_t    vecs [12];

  mem_sdu_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_dout(cpu_dout),
    .sdu_req(sdu_req), .sdu_wr(sdu_wr), .sdu_addr(sdu_addr), .sdu_din(sdu_din),
    .sdu_ack(sdu_ack), .sdu_dout(sdu_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, wanted %08h", name, actual, expected);
    end
  endtask

  // Drives the CPU port for the coming edge and keeps the reference model in step
  task automatic applyStimulus(input logic [3:0] we, input logic [3:0] addr,
                               input logic [31:0] din, input logic re);
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
    cpu_re   = re;
    for (int i = 0; i < 4; i++)
      if (we[i]) model[addr][i*8 +: 8] = din[i*8 +: 8];
  endtask

  task automatic popCompare(input string name);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got empty scoreboard, wanted a pending read", name);
    end else begin
      exp     = exp_q.pop_front();
      last_rd = exp;
      checkOutput(name, sdu_dout, exp);
    end
  endtask

  task automatic waitAck(input string name, input int limit, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!sdu_ack && lat < limit);
    checkOutput({name, "_ack"}, sdu_ack, 32'd1);
  endtask

  task automatic sduRead(input logic [3:0] addr, input string name);
    int lat;
    sdu_req  = 1'b1;
    sdu_wr   = 1'b0;
    sdu_addr = addr;
    exp_q.push_back(model[addr]);
    waitAck(name, 8, lat);
    checkOutput({name, "_lat"}, lat, 32'd1);
    popCompare(name);
    sdu_req = 1'b0;
    tick();
    checkOutput({name, "_pulse"}, sdu_ack, 32'd0);
    tick();
  endtask

  task automatic sduWrite(input logic [3:0] addr, input logic [31:0] data, input string name);
    int lat;
    sdu_req  = 1'b1;
    sdu_wr   = 1'b1;
    sdu_addr = addr;
    sdu_din  = data;
    waitAck(name, 8, lat);
    checkOutput({name, "_lat"}, lat, 32'd1);
    model[addr] = data;
    checkOutput({name, "_dout_hold"}, sdu_dout, last_rd);
    sdu_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, wanted finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int ack_count;
    rst = 1'b1;
    cpu_we = '0; cpu_addr = '0; cpu_din = '0; cpu_re = 1'b0;
    sdu_req = 1'b0; sdu_wr = 1'b0; sdu_addr = '0; sdu_din = '0;
    last_rd = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    vecs[0]  = '{4'hF, 4'd5,  32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{4'h1, 4'd5,  32'h000000AA, 1'b0, 32'h00000000};
    vecs[2]  = '{4'h0, 4'd5,  32'h00000000, 1'b1, 32'hDEADBEAA};
    vecs[3]  = '{4'h0, 4'd6,  32'h00000000, 1'b0, 32'hDEADBEAA};
    vecs[4]  = '{4'hC, 4'd6,  32'h12345678, 1'b1, 32'h00000000};
    vecs[5]  = '{4'h0, 4'd6,  32'h00000000, 1'b1, 32'h12340000};
    vecs[6]  = '{4'h2, 4'd5,  32'h00005500, 1'b1, 32'hDEADBEAA};
    vecs[7]  = '{4'h0, 4'd5,  32'h00000000, 1'b1, 32'hDEAD55AA};
    vecs[8]  = '{4'h8, 4'd0,  32'hFF000000, 1'b0, 32'hDEAD55AA};
    vecs[9]  = '{4'h0, 4'd0,  32'h00000000, 1'b1, 32'hFF000000};
    vecs[10] = '{4'h4, 4'd15, 32'h00AB0000, 1'b1, 32'h00000000};
    vecs[11] = '{4'h0, 4'd15, 32'h00000000, 1'b1, 32'h00AB0000};

    tick();
    tick();
    checkOutput("rst_cpu_dout", cpu_dout, 32'h0);
    checkOutput("rst_sdu_dout", sdu_dout, 32'h0);
    checkOutput("rst_sdu_ack", sdu_ack, 32'h0);

`ifdef MEM_SDU_CLEAR_EN
    checkOutput("rst_busy", busy, 32'd1);
    rst = 1'b0;
    // SDU read raised during the clear must wait for busy to fall
    sdu_req  = 1'b1;
    sdu_wr   = 1'b0;
    sdu_addr = 4'd2;
    exp_q.push_back(model[2]);
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      checkOutput($sformatf("clear_busy_%0d", i), busy, (i < DEPTH) ? 32'd1 : 32'd0);
      checkOutput($sformatf("clear_ack_%0d", i), sdu_ack, 32'd0);
    end
    tick();
    checkOutput("held_off_ack", sdu_ack, 32'd1);
    popCompare("held_off_rd");
    sdu_req = 1'b0;
    tick();
    tick();
`else
    checkOutput("rst_busy", busy, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(4'hF, i[3:0], 32'h0, 1'b0);
      tick();
      checkOutput($sformatf("init_busy_%0d", i), busy, 32'd0);
    end
    applyStimulus(4'h0, 4'd0, 32'h0, 1'b0);
`endif

    for (int i = 0; i < DEPTH; i++)
      sduRead(i[3:0], $sformatf("sdu_rd0_%0d", i));

    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k].we, vecs[k].addr, vecs[k].din, vecs[k].re);
      tick();
      checkOutput($sformatf("cpu_vec_%0d", k), cpu_dout, vecs[k].exp_dout);
    end
    applyStimulus(4'h0, 4'd0, 32'h0, 1'b0);
    sduRead(4'd5, "sdu_rd5");

    // SDU write held off by four cycles of CPU writes
    sdu_req  = 1'b1;
    sdu_wr   = 1'b1;
    sdu_addr = 4'd3;
    sdu_din  = 32'h33333333;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'hF, 4'd8, 32'hA0A0A0A0 + k, 1'b0);
      tick();
      checkOutput($sformatf("sdu_wr_blocked_%0d", k), sdu_ack, 32'd0);
    end
    applyStimulus(4'h0, 4'd8, 32'h0, 1'b0);
    model[3] = 32'h33333333;
    tick();
    checkOutput("sdu_wr_ack_cycle6", sdu_ack, 32'd1);
    checkOutput("sdu_wr_dout_hold", sdu_dout, last_rd);
    sdu_req = 1'b0;
    tick();
    tick();
    applyStimulus(4'h0, 4'd3, 32'h0, 1'b1);
    tick();
    checkOutput("cpu_rd_addr3", cpu_dout, 32'h33333333);
    applyStimulus(4'h0, 4'd8, 32'h0, 1'b1);
    tick();
    checkOutput("cpu_rd_addr8", cpu_dout, 32'hA0A0A0A3);
    applyStimulus(4'h0, 4'd0, 32'h0, 1'b0);
    sduRead(4'd3, "sdu_rd3");

    // Same-cycle CPU write and SDU read of one address
    sduWrite(4'd7, 32'h22222222, "sdu_wr7");
    sdu_req  = 1'b1;
    sdu_wr   = 1'b0;
    sdu_addr = 4'd7;
    exp_q.push_back(model[7]);
    applyStimulus(4'hF, 4'd7, 32'h11111111, 1'b0);
    tick();
    checkOutput("rbw_ack", sdu_ack, 32'd1);
    popCompare("rbw_sdu_dout");
    applyStimulus(4'h0, 4'd7, 32'h0, 1'b1);
    sdu_req = 1'b0;
    tick();
    checkOutput("rbw_cpu_after", cpu_dout, 32'h11111111);
    applyStimulus(4'h0, 4'd0, 32'h0, 1'b0);
    tick();

    // req held high after ack; inputs changed after acceptance must be ignored
    sdu_req  = 1'b1;
    sdu_wr   = 1'b0;
    sdu_addr = 4'd5;
    exp_q.push_back(model[5]);
    waitAck("hold", 8, lat);
    checkOutput("hold_lat", lat, 32'd1);
    popCompare("hold_rd");
    sdu_wr    = 1'b1;
    sdu_addr  = 4'd4;
    sdu_din   = 32'hBAD0BAD0;
    ack_count = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (sdu_ack) ack_count++;
    end
    checkOutput("hold_extra_acks", ack_count, 32'd0);
    sdu_req = 1'b0;
    tick();
    sdu_req  = 1'b1;
    sdu_wr   = 1'b0;
    sdu_addr = 4'd4;
    exp_q.push_back(model[4]);
    waitAck("second", 8, lat);
    checkOutput("second_lat", lat, 32'd1);
    popCompare("second_rd");
    sdu_req = 1'b0;
    tick();
    tick();

`ifdef MEM_SDU_CLEAR_EN
    // Reset when the clear counter has reached 9
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checkOutput($sformatf("clear1_busy_%0d", i), busy, 32'd1);
    end
    rst = 1'b1;
    #1;
    checkOutput("midclr_busy", busy, 32'd1);
    checkOutput("midclr_cpu_dout", cpu_dout, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      checkOutput($sformatf("clear2_busy_%0d", i), busy, (i < DEPTH) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sduRead(4'd5, "post_clear_rd5");
    sduRead(4'd15, "post_clear_rd15");
`else
    // Reset while an SDU write is still held off by the CPU
    sdu_req  = 1'b1;
    sdu_wr   = 1'b1;
    sdu_addr = 4'd9;
    sdu_din  = 32'h99999999;
    applyStimulus(4'hF, 4'd10, 32'h55555555, 1'b0);
    tick();
    checkOutput("pend_ack", sdu_ack, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("pend_rst_cpu_dout", cpu_dout, 32'h0);
    checkOutput("pend_rst_sdu_dout", sdu_dout, 32'h0);
    sdu_req = 1'b0;
    applyStimulus(4'h0, 4'd0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("pend_lost_ack_%0d", k), sdu_ack, 32'd0);
    end
    applyStimulus(4'hF, 4'd9, 32'hAAAA5555, 1'b0);
    tick();
    applyStimulus(4'h0, 4'd9, 32'h0, 1'b1);
    tick();
    checkOutput("post_rst_cpu_rd", cpu_dout, 32'hAAAA5555);
    applyStimulus(4'h0, 4'd0, 32'h0, 1'b0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
